mem_align_unit: RTL
===================

# mem_align_unit

- Sits between the EX/MEM pipeline register and the data memory.
- Turns pipeline byte/halfword/word loads and stores into word-only memory accesses:
  - sub-word stores become a two-cycle read-modify-write;
  - sub-word loads are extracted and sign-extended;
  - misaligned requests are detected and counted.
- The data memory beyond it always sees word operations.

## Interface
Parameters:
- MEM_IDX_W, 12, width of word index forwarded to memory (Address[MEM_IDX_W+1:2]); upper address bits pass through unchanged.

Ports:
- clk  in  1  pipeline clock; FSM and output registers update on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  memory request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- aluCode  in  5  op select: 01001 sh, 00110 sb, 00111 lh, 01000 lb; any other value = word (sw/lw).
- Address  in  32  byte address.
- WriteData  in  32  store data; sub-word data in low bits.
- stall  out  1  freeze upstream pipeline this cycle.
- LoadData  out  32  aligned, sign-extended load result (registered).
- load_valid  out  1  one-cycle pulse, LoadData valid.
- misaligned  out  1  one-cycle pulse, request dropped.
- err_count  out  8  saturating misaligned-request counter.
- mem_Address  out  32  {Address[31:2],2'b00}.
- mem_WriteData  out  32  word to write.
- mem_MemWrite  out  1  memory write enable (memory writes on negedge clk).
- mem_MemRead  out  1  memory read enable (combinational read).
- mem_aluCode  out  5  constant 5'b00000 (word access).
- mem_ReadData  in  32  memory read word.

## Operation
- States:
  - IDLE: accepts requests.
  - MERGE_WR: second cycle of a sub-word store.
- Alignment rules:
  - word: Address[1:0] must be 00.
  - half: Address[0] must be 0.
  - byte: any address.
- Misaligned request in IDLE:
  - no mem_MemRead/mem_MemWrite; stall=0;
  - misaligned pulses next cycle;
  - err_count += 1, saturating at 8'hFF;
  - LoadData unchanged, load_valid=0.
- Aligned load (IDLE): mem_MemRead=1 combinationally. At posedge, LoadData is registered as:
  - lw: mem_ReadData.
  - lh: halfword lane Address[1] (0 → bits 15:0, 1 → bits 31:16), sign-extended.
  - lb: byte lane Address[1:0] (little-endian, lane 0 = bits 7:0), sign-extended.
- Aligned word store (IDLE):
  - mem_MemWrite=1 and mem_WriteData=WriteData combinationally; stall=0.
  - Completes in one cycle.
- Aligned sub-word store (IDLE):
  - mem_MemRead=1 and stall=1 combinationally.
  - At posedge: capture address, lane, size and data; merged word = mem_ReadData with the target lane replaced (WriteData[7:0] or [15:0]).
  - Go to MERGE_WR.
- MERGE_WR:
  - mem_MemWrite=1, mem_WriteData=merged word, mem_MemRead=0, stall=0.
  - req inputs are ignored (upstream still holds the same store).
  - Return to IDLE at posedge.
- req_valid=0 in IDLE: all mem enables 0, stall=0, no state change.
- Outputs that are not registered are 0 when their enabling condition is absent. mem_Address is always derived from the live Address, or from the captured address in MERGE_WR.

## Timing
- Reset values:
  - state IDLE; LoadData 0; load_valid 0; misaligned 0; err_count 0.
  - mem_MemWrite 0 and mem_MemRead 0 while rst_n=0 (gated combinationally).
- Load: request in cycle N; LoadData and load_valid valid in cycle N+1.
- Word store: memory written at negedge of cycle N.
- Sub-word store:
  - cycle N reads; stall=1 in N only;
  - cycle N+1 writes at negedge;
  - upstream advances at end of N+1.
- Back-to-back:
  - A request in the cycle after MERGE_WR is accepted normally.
  - A load following a sub-word store to the same word reads the merged value (write completes at negedge before the load cycle).
- Reset mid-operation: rst_n low during MERGE_WR aborts; no memory write occurs; state IDLE on release.
- err_count at 8'hFF stays 8'hFF; misaligned still pulses.

## Test plan
- Word write then read:
  - sw Address 0x10, data 0xDEADBEEF → mem write at negedge, stall=0.
  - lw 0x10 → next cycle LoadData=0xDEADBEEF, load_valid=1.
- Byte merge with sign extension:
  - Memory[0x20]=0x11223344; sb Address 0x22, WriteData 0x000000AB.
  - Expect stall=1 for one cycle, then write 0x11AB3344.
  - lb 0x22 → LoadData 0xFFFFFFAB.
- Halfword:
  - sh 0x32, data 0x8001 on word 0x00000000 → 0x80010000.
  - lh 0x32 → 0xFFFF8001; lh 0x30 → 0x00000000.
- Misaligned:
  - lw 0x41 → no mem enables, misaligned pulse, err_count=1, load_valid=0.
  - sh 0x43 → err_count=2.
  - 300 misaligned requests → err_count=0xFF.
- Reset during MERGE_WR:
  - sb 0x50, then rst_n=0 in MERGE_WR → no write, memory unchanged, all outputs reset values.
- Back-to-back sb 0x60 then lb 0x60 → load returns the new byte.

Source files
------------

// File: rtl/mem_align_unit_if.sv
// Bundle of pipeline-side request/response signals and the word-only
// data-memory port of mem_align_unit.
interface mem_align_unit_if;
  // Pipeline request
  logic        req_valid;
  logic        req_write;
  logic [4:0]  aluCode;
  logic [31:0] Address;
  logic [31:0] WriteData;
  // Pipeline response
  logic        stall;
  logic [31:0] LoadData;
  logic        load_valid;
  logic        misaligned;
  logic [7:0]  err_count;
  // Data-memory side
  logic [31:0] mem_Address;
  logic [31:0] mem_WriteData;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic [4:0]  mem_aluCode;
  logic [31:0] mem_ReadData;

  // The alignment unit itself
  modport slave (
    input  req_valid, req_write, aluCode, Address, WriteData, mem_ReadData,
    output stall, LoadData, load_valid, misaligned, err_count,
           mem_Address, mem_WriteData, mem_MemWrite, mem_MemRead, mem_aluCode
  );

  // Pipeline plus data memory surrounding the unit
  modport master (
    output req_valid, req_write, aluCode, Address, WriteData, mem_ReadData,
    input  stall, LoadData, load_valid, misaligned, err_count,
           mem_Address, mem_WriteData, mem_MemWrite, mem_MemRead, mem_aluCode
  );
endinterface

// File: rtl/mem_align_unit.sv
// Converts byte/halfword/word loads and stores into word-only memory
// accesses: sub-word stores become a read-modify-write, sub-word loads are
// lane-extracted and sign-extended, misaligned requests are dropped and counted.
module mem_align_unit #(
  parameter int MEM_IDX_W = 12  // word-index bits; must stay below 30
) (
  input logic            clk,
  input logic            rst_n,
  mem_align_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_MERGE_WR} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  localparam logic [4:0] OP_SH = 5'b01001;
  localparam logic [4:0] OP_SB = 5'b00110;
  localparam logic [4:0] OP_LH = 5'b00111;
  localparam logic [4:0] OP_LB = 5'b01000;

  state_t      r_state;
  state_t      w_next_state;
  logic [29:0] r_word_addr;
  logic [31:0] r_merge_data;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_misaligned;
  logic [7:0]  r_err_count;

  size_t       w_size;
  logic        w_aligned;
  logic        w_accept;
  logic        w_req_misaligned;
  logic        w_req_load;
  logic        w_req_word_store;
  logic        w_req_sub_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge_word;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_stall;
  logic [31:0] w_mem_wdata;
  logic [29:0] w_word_addr_sel;

  // Decode access size and check address alignment for that size
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_size    = SZ_WORD;
    w_aligned = 1'b1;
    case (bus.aluCode)
      OP_SH, OP_LH: w_size = SZ_HALF;
      OP_SB, OP_LB: w_size = SZ_BYTE;
      default:      w_size = SZ_WORD;
    endcase
    case (w_size)
      SZ_WORD: w_aligned = (bus.Address[1:0] == 2'b00);
      SZ_HALF: w_aligned = ~bus.Address[0];
      default: w_aligned = 1'b1;
    endcase
  end

  // Requests are only taken in IDLE; MERGE_WR ignores the held store
  assign w_accept         = (r_state == S_IDLE) && bus.req_valid;
  assign w_req_misaligned = w_accept && !w_aligned;
  assign w_req_load       = w_accept &&  w_aligned && !bus.req_write;
  assign w_req_word_store = w_accept &&  w_aligned &&  bus.req_write && (w_size == SZ_WORD);
  assign w_req_sub_store  = w_accept &&  w_aligned &&  bus.req_write && (w_size != SZ_WORD);

  // Lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    w_byte       = bus.mem_ReadData[{bus.Address[1:0], 3'b000} +: 8];
    w_half       = bus.Address[1] ? bus.mem_ReadData[31:16] : bus.mem_ReadData[15:0];
    w_load_ext   = bus.mem_ReadData;
    w_merge_word = bus.mem_ReadData;
    case (w_size)
      SZ_HALF: begin
        w_load_ext = {{16{w_half[15]}}, w_half};
        if (bus.Address[1]) w_merge_word[31:16] = bus.WriteData[15:0];
        else                w_merge_word[15:0]  = bus.WriteData[15:0];
      end
      SZ_BYTE: begin
        w_load_ext = {{24{w_byte[7]}}, w_byte};
        w_merge_word[{bus.Address[1:0], 3'b000} +: 8] = bus.WriteData[7:0];
      end
      default: ;
    endcase
  end

  // FSM next state and memory-side controls
  always_comb begin
    w_next_state    = r_state;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_stall         = 1'b0;
    w_mem_wdata     = '0;
    w_word_addr_sel = bus.Address[31:2];
    case (r_state)
      S_IDLE: begin
        if (w_req_load || w_req_sub_store) w_mem_read = 1'b1;
        if (w_req_word_store) begin
          w_mem_write = 1'b1;
          w_mem_wdata = bus.WriteData;
        end
        if (w_req_sub_store) begin
          w_stall      = 1'b1;
          w_next_state = S_MERGE_WR;
        end
      end
      S_MERGE_WR: begin
        w_mem_write     = 1'b1;
        w_mem_wdata     = r_merge_data;
        w_word_addr_sel = r_word_addr;
        w_next_state    = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; an asynchronous reset aborts a pending merge write
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Registered load result, misalignment pulse/counter and merge capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_err_count  <= '0;
      r_word_addr  <= '0;
      r_merge_data <= '0;
    end else begin
      r_load_valid <= w_req_load;
      r_misaligned <= w_req_misaligned;
      if (w_req_load) r_load_data <= w_load_ext;
      if (w_req_misaligned && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_req_sub_store) begin
        r_word_addr  <= bus.Address[31:2];
        r_merge_data <= w_merge_word;
      end
    end
  end

  // Memory enables are forced low while reset is held
  assign bus.mem_MemRead   = w_mem_read  & rst_n;
  assign bus.mem_MemWrite  = w_mem_write & rst_n;
  assign bus.stall         = w_stall     & rst_n;
  assign bus.mem_WriteData = w_mem_wdata;
  assign bus.mem_Address   = {w_word_addr_sel[29:MEM_IDX_W],
                              w_word_addr_sel[MEM_IDX_W-1:0], 2'b00};
  assign bus.mem_aluCode   = 5'b00000;
  assign bus.LoadData      = r_load_data;
  assign bus.load_valid    = r_load_valid;
  assign bus.misaligned    = r_misaligned;
  assign bus.err_count     = r_err_count;

endmodule
